// File: rtl/rtc_time_writer_if.sv
// Handshake and RTC parallel-bus bundle for rtc_time_writer.
// master: the edit-register side plus bus observers; slave: the writer itself.
interface rtc_time_writer_if;
  logic       START;
  logic [7:0] SEG_in;
  logic [7:0] MIN_in;
  logic [7:0] HOR_in;
  logic       BUSY;
  logic       DONE;
  logic       ERR;
  logic [7:0] AD_out;
  logic       AD_oe;
  logic       CS_n;
  logic       RD_n;
  logic       WR_n;
  logic       A_D;

  modport master (
    output START, SEG_in, MIN_in, HOR_in,
    input  BUSY, DONE, ERR, AD_out, AD_oe, CS_n, RD_n, WR_n, A_D
  );

  modport slave (
    input  START, SEG_in, MIN_in, HOR_in,
    output BUSY, DONE, ERR, AD_out, AD_oe, CS_n, RD_n, WR_n, A_D
  );
endinterface

// File: rtl/rtc_time_writer.sv
// rtc_time_writer: validates edited BCD seconds/minutes/hours and writes them
// to the RTC over its multiplexed A/D bus as address/data pairs.
// Optional macro RTC_WR_TRANSFER_EN appends a 0xF2/0xF2 transfer command write.
//
// state  | meaning
// IDLE   | waiting for START, bus released
// CHECK  | one cycle BCD range check of the latched bytes
// SETUP  | AD driven, strobes high (address/data setup)
// STROBE | CS_n/WR_n low for T_PULSE cycles
// HOLD   | strobes high, AD still driven
// GAP    | AD released for T_GAP cycles, then next phase or finish
// FINISH | one cycle, DONE pulses as it leaves
module rtc_time_writer #(
  parameter int T_PULSE = 10,
  parameter int T_GAP   = 5
) (
  input  logic              CLK,
  input  logic              RST_N,
  rtc_time_writer_if.slave  bus
);

  localparam int TMAX = (T_PULSE > T_GAP) ? T_PULSE : T_GAP;
  localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [CW-1:0] PULSE_LD = CW'(T_PULSE - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(T_GAP - 1);
`ifdef RTC_WR_TRANSFER_EN
  localparam logic [1:0] LAST_IDX = 2'd3;
`else
  localparam logic [1:0] LAST_IDX = 2'd2;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_SETUP, S_STROBE, S_HOLD, S_GAP, S_FINISH
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    idx, idx_nxt;
  logic          phase, phase_nxt;      // 0 = address, 1 = data
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    seg_q, seg_nxt;
  logic [7:0]    min_q, min_nxt;
  logic [7:0]    hor_q, hor_nxt;
  logic          busy, busy_nxt;
  logic          done, done_nxt;
  logic          err, err_nxt;
  logic [7:0]    ad_out, ad_out_nxt;
  logic          ad_oe, ad_oe_nxt;
  logic          cs_n, cs_n_nxt;
  logic          wr_n, wr_n_nxt;
  logic          a_d, a_d_nxt;

  function automatic logic bcd_ok(input logic [7:0] s, input logic [7:0] m,
                                  input logic [7:0] h);
    return (s[3:0] <= 4'd9) && (s[7:4] <= 4'd5) &&
           (m[3:0] <= 4'd9) && (m[7:4] <= 4'd5) &&
           (h[3:0] <= 4'd9) && (h <= 8'h23);
  endfunction

  function automatic logic [7:0] addr_byte(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h21;
      2'd1:    return 8'h22;
      2'd2:    return 8'h23;
      default: return 8'hF2;
    endcase
  endfunction

  function automatic logic [7:0] data_byte(input logic [1:0] i, input logic [7:0] s,
                                           input logic [7:0] m, input logic [7:0] h);
    case (i)
      2'd0:    return s;
      2'd1:    return m;
      2'd2:    return h;
      default: return 8'hF2;
    endcase
  endfunction

  // Next-state, sequencing counter and status flags.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    phase_nxt = phase;
    cnt_nxt   = cnt;
    seg_nxt   = seg_q;
    min_nxt   = min_q;
    hor_nxt   = hor_q;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    err_nxt   = err;
    unique case (state)
      S_IDLE: begin
        if (bus.START) begin
          seg_nxt   = bus.SEG_in;
          min_nxt   = bus.MIN_in;
          hor_nxt   = bus.HOR_in;
          err_nxt   = 1'b0;
          busy_nxt  = 1'b1;
          state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!bcd_ok(seg_q, min_q, hor_q)) begin
          err_nxt   = 1'b1;
          state_nxt = S_FINISH;
        end else begin
          idx_nxt   = 2'd0;
          phase_nxt = 1'b0;
          state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_nxt   = PULSE_LD;
        state_nxt = S_STROBE;
      end
      S_STROBE: begin
        if (cnt == '0) state_nxt = S_HOLD;
        else           cnt_nxt   = cnt - CW'(1);
      end
      S_HOLD: begin
        cnt_nxt   = GAP_LD;
        state_nxt = S_GAP;
      end
      S_GAP: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end else if (!phase) begin
          phase_nxt = 1'b1;
          state_nxt = S_SETUP;
        end else if (idx != LAST_IDX) begin
          idx_nxt   = idx + 2'd1;
          phase_nxt = 1'b0;
          state_nxt = S_SETUP;
        end else begin
          state_nxt = S_FINISH;
        end
      end
      S_FINISH: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs decoded from the next state so the strobes come straight from flops.
  always_comb begin
    ad_out_nxt = 8'h00;
    ad_oe_nxt  = 1'b0;
    cs_n_nxt   = 1'b1;
    wr_n_nxt   = 1'b1;
    a_d_nxt    = 1'b1;
    if (state_nxt == S_SETUP || state_nxt == S_STROBE || state_nxt == S_HOLD) begin
      ad_oe_nxt  = 1'b1;
      a_d_nxt    = phase_nxt;
      ad_out_nxt = phase_nxt ? data_byte(idx_nxt, seg_nxt, min_nxt, hor_nxt)
                             : addr_byte(idx_nxt);
      if (state_nxt == S_STROBE) begin
        cs_n_nxt = 1'b0;
        wr_n_nxt = 1'b0;
      end
    end
  end

  // State, datapath and output registers; reset releases the bus at once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= S_IDLE;
      idx    <= 2'd0;
      phase  <= 1'b0;
      cnt    <= '0;
      seg_q  <= 8'h00;
      min_q  <= 8'h00;
      hor_q  <= 8'h00;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      ad_out <= 8'h00;
      ad_oe  <= 1'b0;
      cs_n   <= 1'b1;
      wr_n   <= 1'b1;
      a_d    <= 1'b1;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      phase  <= phase_nxt;
      cnt    <= cnt_nxt;
      seg_q  <= seg_nxt;
      min_q  <= min_nxt;
      hor_q  <= hor_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      err    <= err_nxt;
      ad_out <= ad_out_nxt;
      ad_oe  <= ad_oe_nxt;
      cs_n   <= cs_n_nxt;
      wr_n   <= wr_n_nxt;
      a_d    <= a_d_nxt;
    end
  end

  assign bus.BUSY   = busy;
  assign bus.DONE   = done;
  assign bus.ERR    = err;
  assign bus.AD_out = ad_out;
  assign bus.AD_oe  = ad_oe;
  assign bus.CS_n   = cs_n;
  assign bus.RD_n   = 1'b1;
  assign bus.WR_n   = wr_n;
  assign bus.A_D    = a_d;

endmodule

// File: tb/tb_rtc_time_writer.sv
// Bench for rtc_time_writer: a default-timed instance and a T_PULSE=T_GAP=1
// instance share the stimulus; a select bit picks which one is exercised.
module tb_rtc_time_writer;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  rtc_time_writer_if ifa ();
  rtc_time_writer_if ifb ();

  logic       start, sel;
  logic [7:0] seg_v, min_v, hor_v;

  assign ifa.START  = start & ~sel;
  assign ifb.START  = start & sel;
  assign ifa.SEG_in = seg_v;
  assign ifa.MIN_in = min_v;
  assign ifa.HOR_in = hor_v;
  assign ifb.SEG_in = seg_v;
  assign ifb.MIN_in = min_v;
  assign ifb.HOR_in = hor_v;

  rtc_time_writer #(.T_PULSE(10), .T_GAP(5)) dut_a (.CLK(CLK), .RST_N(RST_N), .bus(ifa.slave));
  rtc_time_writer #(.T_PULSE(1),  .T_GAP(1)) dut_b (.CLK(CLK), .RST_N(RST_N), .bus(ifb.slave));

  logic       m_busy, m_done, m_err, m_oe, m_cs, m_rd, m_wr, m_ad_sel;
  logic [7:0] m_ad;
  assign m_busy   = sel ? ifb.BUSY   : ifa.BUSY;
  assign m_done   = sel ? ifb.DONE   : ifa.DONE;
  assign m_err    = sel ? ifb.ERR    : ifa.ERR;
  assign m_oe     = sel ? ifb.AD_oe  : ifa.AD_oe;
  assign m_cs     = sel ? ifb.CS_n   : ifa.CS_n;
  assign m_rd     = sel ? ifb.RD_n   : ifa.RD_n;
  assign m_wr     = sel ? ifb.WR_n   : ifa.WR_n;
  assign m_ad_sel = sel ? ifb.A_D    : ifa.A_D;
  assign m_ad     = sel ? ifb.AD_out : ifa.AD_out;

`ifdef RTC_WR_TRANSFER_EN
  localparam int NWR = 4;
`else
  localparam int NWR = 3;
`endif

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: decimal range rules on the BCD digits.
  function automatic bit ref_valid(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h);
    int st, so, mt, mo, ht, ho;
    st = s / 16; so = s % 16; mt = m / 16; mo = m % 16; ht = h / 16; ho = h % 16;
    return (so <= 9) && (st <= 5) && (mo <= 9) && (mt <= 5) && (ho <= 9) &&
           ((ht * 10 + ho) <= 23);
  endfunction

  // Runs one request on the selected instance and watches the bus cycle by cycle.
  task automatic run_txn(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h,
                         input bit exp_err, input bit noise);
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    logic [8:0] cur;
    int tp, tg, exp_lat, n, lat, low, last_fall, viol;
    logic prev_cs, prev_oe, prev_sel;
    logic [7:0] prev_ad;
    bit seen;
    tp = sel ? 1 : 10;
    tg = sel ? 1 : 5;
    if (!exp_err) begin
      exp_q.push_back({1'b0, 8'h21}); exp_q.push_back({1'b1, s});
      exp_q.push_back({1'b0, 8'h22}); exp_q.push_back({1'b1, m});
      exp_q.push_back({1'b0, 8'h23}); exp_q.push_back({1'b1, h});
      if (NWR == 4) begin
        exp_q.push_back({1'b0, 8'hF2}); exp_q.push_back({1'b1, 8'hF2});
      end
    end
    exp_lat = exp_err ? 3 : 3 + 2 * NWR * (tp + tg + 2);
    @(posedge CLK); #1;
    seg_v = s; min_v = m; hor_v = h; start = 1'b1;
    n = 0; lat = -1; seen = 0; low = 0; last_fall = -1; viol = 0; cur = '0;
    prev_cs = 1'b1; prev_oe = 1'b0; prev_ad = 8'h00; prev_sel = 1'b1;
    while (!seen && n < exp_lat + 20) begin
      @(posedge CLK); #1;
      n++;
      if (n == 1) begin
        start = 1'b0;
        check("busy_rise", m_busy, 1'b1);
      end
      if (noise && n == 40) begin start = 1'b1; seg_v = 8'h00; end
      if (noise && n == 41) start = 1'b0;
      if (n == exp_lat - 1) start = 1'b1;     // lands on FINISH, must be ignored
      if (n == exp_lat) start = 1'b0;
      if (m_cs !== m_wr || m_rd !== 1'b1) viol++;
      if (m_cs == 1'b0 && prev_cs == 1'b1) begin
        cur = {m_ad_sel, m_ad};
        got_q.push_back(cur);
        if (!(prev_oe && prev_ad == m_ad && prev_sel == m_ad_sel)) viol++;
        if (last_fall >= 0 && (n - last_fall) != tp + tg + 2) viol++;
        last_fall = n;
        low = 1;
      end else if (m_cs == 1'b0) begin
        low++;
        if ({m_ad_sel, m_ad} !== cur || !m_oe) viol++;
      end else if (prev_cs == 1'b0) begin
        check("wr_pulse_width", low, tp);
        if (!(m_oe && {m_ad_sel, m_ad} == cur)) viol++;
      end
      if (m_done) begin seen = 1; lat = n; end
      prev_cs = m_cs; prev_oe = m_oe; prev_ad = m_ad; prev_sel = m_ad_sel;
    end
    start = 1'b0;
    check("done_latency", lat, exp_lat);
    check("err_flag", m_err, exp_err);
    check("busy_at_done", m_busy, 1'b0);
    check("bus_protocol_violations", viol, 0);
    check("write_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("bus_byte_%0d", i), got_q[i], exp_q[i]);
    @(posedge CLK); #1;
    check("done_one_cycle", m_done, 1'b0);
    check("finish_start_ignored", m_busy, 1'b0);
  endtask

  typedef struct {
    logic [7:0] seg;
    logic [7:0] min;
    logic [7:0] hor;
    bit         use_b;
    bit         noise;
    bit         exp_err;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int waits, dones;
    logic [7:0] rs, rm, rh;
    tbl[0] = '{8'h45, 8'h30, 8'h12, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h5A, 8'h30, 8'h12, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{8'h45, 8'h60, 8'h12, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{8'h45, 8'h30, 8'h24, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{8'h59, 8'h00, 8'h23, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{8'h45, 8'h30, 8'h12, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{8'h00, 8'h59, 8'h1A, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{8'h59, 8'h00, 8'h23, 1'b0, 1'b0, 1'b0};

    RST_N = 1'b0; start = 1'b0; sel = 1'b0;
    seg_v = 8'h00; min_v = 8'h00; hor_v = 8'h00;
    #12;
    check("rst_busy", ifa.BUSY, 1'b0);
    check("rst_done", ifa.DONE, 1'b0);
    check("rst_err", ifa.ERR, 1'b0);
    check("rst_ad_out", ifa.AD_out, 8'h00);
    check("rst_ad_oe", ifa.AD_oe, 1'b0);
    check("rst_strobes", {ifa.CS_n, ifa.RD_n, ifa.WR_n, ifa.A_D}, 4'hF);
    #11 RST_N = 1'b1;

    for (int i = 0; i < 8; i++) begin
      sel = tbl[i].use_b;
      run_txn(tbl[i].seg, tbl[i].min, tbl[i].hor, tbl[i].exp_err, tbl[i].noise);
    end

    // Reset during the MIN data strobe, then a fresh request.
    sel = 1'b0;
    @(posedge CLK); #1;
    seg_v = 8'h45; min_v = 8'h30; hor_v = 8'h12; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    waits = 0;
    while (!(ifa.CS_n == 1'b0 && ifa.A_D == 1'b1 && ifa.AD_out == 8'h30) && waits < 200) begin
      @(posedge CLK); #1;
      waits++;
    end
    check("reached_min_strobe", waits < 200, 1'b1);
    @(posedge CLK); #2;
    RST_N = 1'b0;
    #1;
    check("async_rst_strobes", {ifa.CS_n, ifa.WR_n}, 2'b11);
    check("async_rst_ad_oe", ifa.AD_oe, 1'b0);
    check("async_rst_busy", ifa.BUSY, 1'b0);
    repeat (2) @(posedge CLK);
    #3 RST_N = 1'b1;
    dones = 0;
    for (int c = 0; c < 120; c++) begin
      @(posedge CLK); #1;
      if (ifa.DONE) dones++;
    end
    check("no_done_after_abort", dones, 0);
    run_txn(8'h45, 8'h30, 8'h12, 1'b0, 1'b0);

    // Randomized requests against the reference rules.
    for (int k = 0; k < 20; k++) begin
      sel = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        rs = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
        rm = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
        rh = 8'($urandom_range(0, 23));
        rh = {4'(rh / 10), 4'(rh % 10)};
      end else begin
        rs = 8'($urandom_range(0, 255));
        rm = 8'($urandom_range(0, 255));
        rh = 8'($urandom_range(0, 255));
      end
      run_txn(rs, rm, rh, !ref_valid(rs, rm, rh), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rtc_time_writer.md
# rtc_time_writer

Write-back engine for the RTC time registers. When the user finishes editing seconds, minutes and hours, this block validates the three BCD bytes. It then drives the RTC's multiplexed parallel bus (A/D-select, CS, RD, WR, 8-bit AD) to write them into the chip, optionally followed by the transfer command. It sits between the edit registers and the shared RTC bus arbiter, and is the write path opposite the register-load (read/update) path.

## Interface

- T_PULSE, 10: cycles CS_n/WR_n held low per bus phase; minimum 1.
- T_GAP, 5: idle cycles after each bus phase, AD released; minimum 1.
- CLK  in  1  system clock, all logic on rising edge.
- RST_N  in  1  reset, asynchronous and active-low.
- START  in  1  one-cycle request to write the edited time; ignored while BUSY=1.
- SEG_in  in  8  seconds, packed BCD 0x00–0x59.
- MIN_in  in  8  minutes, packed BCD 0x00–0x59.
- HOR_in  in  8  hours, packed BCD 0x00–0x23.
- BUSY  out  1  sequence in progress.
- DONE  out  1  one-cycle pulse at end of sequence, including the rejected case.
- ERR  out  1  last request rejected as invalid BCD; holds until next accepted START.
- AD_out  out  8  value driven on the RTC AD bus.
- AD_oe  out  1  tristate enable for AD_out, 1 = drive.
- CS_n, RD_n, WR_n  out  1 each  RTC strobes, active-low; RD_n is constant 1.
- A_D  out  1  0 = address phase, 1 = data phase.

## Operation

- States: IDLE, CHECK, SETUP, STROBE, HOLD, GAP, FINISH.
- IDLE:
  - START=1 latches SEG_in, MIN_in and HOR_in, clears ERR, sets BUSY.
  - Next state is CHECK.
- CHECK (1 cycle): the request is invalid if any of these holds:
  - any nibble > 9;
  - SEG or MIN tens nibble > 5;
  - HOR > 0x23.
- Invalid request: set ERR, go to FINISH. No bus activity.
- Valid request: write index = 0, phase = address, go to SETUP.
- Write list, as address/data pairs:
  - 0x21/SEG
  - 0x22/MIN
  - 0x23/HOR
  - with RTC_WR_TRANSFER_EN: 0xF2/0xF2
- SETUP (1 cycle): AD_oe=1; AD_out = address or data byte; A_D = phase bit; CS_n=WR_n=1.
- STROBE (T_PULSE cycles): CS_n=0, WR_n=0, AD_out and A_D stable.
- HOLD (1 cycle): CS_n=WR_n=1, AD_out still driven.
- GAP (T_GAP cycles): AD_oe=0, AD_out=0x00, A_D=1. At the end of GAP:
  - after an address phase: next phase is data, go to SETUP;
  - after a data phase with writes remaining: increment the index, phase = address, go to SETUP;
  - otherwise: go to FINISH.
- FINISH (1 cycle): DONE=1, BUSY=0 at the following edge, return to IDLE.
- A single down-counter, sized for max(T_PULSE, T_GAP), times STROBE and GAP.
- START during BUSY has no effect.
- Input changes after START do not affect the write in progress.
- Reset values:
  - BUSY=0, DONE=0, ERR=0
  - AD_out=0x00, AD_oe=0
  - CS_n=1, RD_n=1, WR_n=1, A_D=1
  - state IDLE
- RST_N low mid-sequence: strobes return high and AD_oe=0 immediately (asynchronously). The partial write is abandoned; DONE is not pulsed.

## Timing

- BUSY rises on the first edge after START is sampled.
- CHECK occupies the next cycle.
- Bus phase = T_PULSE + T_GAP + 2 cycles; one write = 2 phases.
- Defaults: 17-cycle phase, 34-cycle write.
- Valid request, START edge to DONE pulse:
  - 3 writes: 1 + 1 + 102 + 1 cycles;
  - 4 writes (transfer enabled): 1 + 1 + 136 + 1 cycles.
- Rejected request: DONE and ERR high 3 cycles after the START edge.
- AD_out is valid 1 cycle before CS_n/WR_n fall and 1 cycle after they rise.
- AD_out never changes while CS_n=0.
- START coincident with FINISH is ignored; START is accepted in IDLE only.

## Configuration

- RTC_WR_TRANSFER_EN defined: after the HOR write, a fourth write issues 0xF2 address then 0xF2 data. This commands the RTC to copy the written time into its counters.
- Not defined: the sequence ends after the HOR write. The transfer is issued by the separate command block.

## Test plan

- Reset, then START with SEG=0x45, MIN=0x30, HOR=0x12, defaults, macro off:
  - bus shows A_D=0 AD=0x21, A_D=1 AD=0x45, then 0x22/0x30, then 0x23/0x12;
  - each WR_n low pulse is exactly 10 cycles;
  - DONE arrives 105 cycles after START; ERR=0.
- Same stimulus, macro on:
  - a fourth pair 0xF2/0xF2 follows;
  - DONE arrives 139 cycles after START.
- START with SEG=0x5A, then separately with MIN=0x60, then HOR=0x24:
  - each gives DONE and ERR=1 at 3 cycles;
  - CS_n stays 1 throughout.
- START pulses during BUSY, with SEG_in changed to 0x00 mid-sequence:
  - extra STARTs ignored;
  - bytes written match the values latched at the first START.
- Boundary values SEG=0x59, MIN=0x00, HOR=0x23 with T_PULSE=1, T_GAP=1:
  - all accepted;
  - 4-cycle phases; strobe and data setup/hold each 1 cycle.
- RST_N low during the STROBE of the MIN data phase:
  - CS_n, WR_n = 1 and AD_oe=0 within the same cycle;
  - no DONE;
  - after release, a fresh START completes normally.
